// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver sampling an oversampled baud tick
module uart_rx #(
    parameter int OVERSAMPLE = 8,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [SW-1:0] MID_START   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] LAST_SAMPLE = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT    = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rx_s;
    logic [SW-1:0]        sample_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Strobes default low every cycle so each lasts exactly one clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (baud_tick) begin
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            sample_cnt <= '0;
                            state      <= START;
                            busy       <= 1'b1;
                        end
                    end
                    START: begin
                        sample_cnt <= sample_cnt + 1'b1;
                        if (sample_cnt == MID_START) begin
                            if (rx_s) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                sample_cnt <= '0;
                                bit_cnt    <= '0;
                                state      <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        sample_cnt <= sample_cnt + 1'b1;
                        if (sample_cnt == LAST_SAMPLE) begin
                            sample_cnt <= '0;
                            shift_reg  <= {rx_s, shift_reg[DATA_BITS-1:1]};
                            bit_cnt    <= bit_cnt + 1'b1;
                            if (bit_cnt == LAST_BIT) begin
                                state <= STOP;
                            end
                        end
                    end
                    STOP: begin
                        sample_cnt <= sample_cnt + 1'b1;
                        if (sample_cnt == LAST_SAMPLE) begin
                            sample_cnt <= '0;
                            if (rx_s) begin
                                data       <= shift_reg;
                                data_valid <= 1'b1;
                                state      <= IDLE;
                                busy       <= 1'b0;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= BREAK;
                            end
                        end
                    end
                    BREAK: begin
                        // A held-low line must rise before another start is accepted.
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
